// File: rtl/write_buffer.sv
// Posted-write buffer between the last cache level and mainMem: queues writes, answers
// buffered reads, drains in the background. Define WRITE_BUFFER_COALESCE_EN to merge same-address writes.
module write_buffer #(
  parameter int ADDR_LENGTH = 11,
  parameter int BLOCK_SIZE  = 128,
  parameter int DEPTH       = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_LENGTH-1:0]     addrIn,
  output logic [BLOCK_SIZE-1:0]      dataUpOut,
  input  logic [BLOCK_SIZE-1:0]      dataUpIn,
  output logic                       fetchComplete,
  input  logic                       enableIn,
  output logic                       writeCompleteOut,
  input  logic                       writeIn,
  output logic [ADDR_LENGTH-1:0]     addrOut,
  input  logic [BLOCK_SIZE-1:0]      dataDownIn,
  output logic [BLOCK_SIZE-1:0]      dataDownOut,
  input  logic                       fetchReceive,
  output logic                       enableOut,
  input  logic                       writeCompleteIn,
  output logic                       writeOut,
  output logic [1:0]                 stateDbg,
  output logic [$clog2(DEPTH):0]     countDbg
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshakes: enableIn/enableOut are level requests held until the matching
  // completion; completions toward the cache stay high until enableIn drops.
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, RD_MEM = 2'd2, DRAIN = 2'd3} state_t;

  state_t                  state, stateNext;
  logic [ADDR_LENGTH-1:0]  addrMem [DEPTH];
  logic [BLOCK_SIZE-1:0]   dataMem [DEPTH];
  logic [DEPTH-1:0]        validMem;
  logic [PTR_W-1:0]        head, tail;
  logic [PTR_W:0]          count;
  logic                    full;
  logic                    hit;
  logic [PTR_W-1:0]        hitIdx;
  logic                    pushEn, popEn, coalesceEn, writeAccept;

  logic [BLOCK_SIZE-1:0]   dataUpNext, dataDownNext;
  logic [ADDR_LENGTH-1:0]  addrOutNext;
  logic                    fetchCompleteNext, writeCompleteNext, enableOutNext, writeOutNext;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign stateDbg = state;
  assign countDbg = count;

  // Scan oldest to newest so the last match (newest entry) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (validMem[idx] && (addrMem[idx] == addrIn)) begin
        hit    = 1'b1;
        hitIdx = idx;
      end
    end
  end

`ifdef WRITE_BUFFER_COALESCE_EN
  assign writeAccept = !full || hit;
`else
  assign writeAccept = !full;
`endif

  always_comb begin
    stateNext         = state;
    dataUpNext        = dataUpOut;
    dataDownNext      = dataDownOut;
    addrOutNext       = addrOut;
    fetchCompleteNext = fetchComplete;
    writeCompleteNext = writeCompleteOut;
    enableOutNext     = enableOut;
    writeOutNext      = writeOut;
    pushEn            = 1'b0;
    popEn             = 1'b0;
    coalesceEn        = 1'b0;
    case (state)
      IDLE: begin
        if (enableIn && !writeIn) begin
          if (hit) begin
            dataUpNext        = dataMem[hitIdx];
            fetchCompleteNext = 1'b1;
            stateNext         = ACK;
          end else begin
            // No buffered entry matches, so memory holds the current data.
            addrOutNext   = addrIn;
            writeOutNext  = 1'b0;
            enableOutNext = 1'b1;
            stateNext     = RD_MEM;
          end
        end else if (enableIn && writeIn && writeAccept) begin
`ifdef WRITE_BUFFER_COALESCE_EN
          if (hit) coalesceEn = 1'b1;
          else     pushEn     = 1'b1;
`else
          pushEn = 1'b1;
`endif
          writeCompleteNext = 1'b1;
          stateNext         = ACK;
        end else if (count != '0) begin
          // Also reached by a write stalled on a full buffer.
          addrOutNext   = addrMem[head];
          dataDownNext  = dataMem[head];
          writeOutNext  = 1'b1;
          enableOutNext = 1'b1;
          stateNext     = DRAIN;
        end
      end
      ACK: begin
        if (!enableIn) begin
          fetchCompleteNext = 1'b0;
          writeCompleteNext = 1'b0;
          stateNext         = IDLE;
        end
      end
      RD_MEM: begin
        if (fetchReceive) begin
          dataUpNext        = dataDownIn;
          fetchCompleteNext = 1'b1;
          enableOutNext     = 1'b0;
          stateNext         = ACK;
        end
      end
      DRAIN: begin
        if (writeCompleteIn) begin
          popEn         = 1'b1;
          enableOutNext = 1'b0;
          writeOutNext  = 1'b0;
          stateNext     = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      validMem         <= '0;
      dataUpOut        <= '0;
      dataDownOut      <= '0;
      addrOut          <= '0;
      fetchComplete    <= 1'b0;
      writeCompleteOut <= 1'b0;
      enableOut        <= 1'b0;
      writeOut         <= 1'b0;
    end else begin
      state            <= stateNext;
      dataUpOut        <= dataUpNext;
      dataDownOut      <= dataDownNext;
      addrOut          <= addrOutNext;
      fetchComplete    <= fetchCompleteNext;
      writeCompleteOut <= writeCompleteNext;
      enableOut        <= enableOutNext;
      writeOut         <= writeOutNext;
      if (pushEn) begin
        tail           <= tail + PTR_W'(1);
        validMem[tail] <= 1'b1;
        count          <= count + (PTR_W+1)'(1);
      end
      if (popEn) begin
        head           <= head + PTR_W'(1);
        validMem[head] <= 1'b0;
        count          <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Entry payload needs no reset; validMem qualifies it.
  always_ff @(posedge clock) begin
    if (pushEn) begin
      addrMem[tail] <= addrIn;
      dataMem[tail] <= dataUpIn;
    end
    if (coalesceEn) dataMem[hitIdx] <= dataUpIn;
  end

endmodule
